// File: rtl/rcv_sample_assembler.sv
// Receive-side control for the FIR serial link: pairs two UART bytes (LSB, then MSB)
// into a 16-bit sample and hands it to the FIR over a valid/ready handshake.
module rcv_sample_assembler #(
    parameter logic [19:0] TIMEOUT_CYCLES = 20'd100000,
    parameter int unsigned TMR_W          = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RxD_data_ready,
    input  logic [7:0]  RxD_data,
    input  logic        FIR_ready,
    output logic [15:0] FIR_sample,
    output logic        FIR_valid_in,
    output logic        overrun,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GET_MSB = 2'd1,
        PRESENT = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [7:0]         lsb_reg;
    logic [7:0]         lsb_nxt;
    logic [TMR_W-1:0]   timer;
    logic [TMR_W-1:0]   timer_nxt;
    logic [15:0]        sample_nxt;
    logic               valid_nxt;
    logic               overrun_nxt;
    logic               timeout_nxt;
    logic               expired;

    // Last cycle the MSB may still arrive; a strobe on this cycle still completes the sample.
    assign expired = (TIMEOUT_CYCLES != 20'd0) &&
                     (timer == TMR_W'(TIMEOUT_CYCLES - 20'd1));

    // State register; all outputs and datapath registers load here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            lsb_reg      <= 8'd0;
            timer        <= '0;
            FIR_sample   <= 16'd0;
            FIR_valid_in <= 1'b0;
            overrun      <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            state        <= state_nxt;
            lsb_reg      <= lsb_nxt;
            timer        <= timer_nxt;
            FIR_sample   <= sample_nxt;
            FIR_valid_in <= valid_nxt;
            overrun      <= overrun_nxt;
            timeout_err  <= timeout_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = RxD_data_ready ? GET_MSB : IDLE;
            GET_MSB: begin
                if (RxD_data_ready)  state_nxt = PRESENT;
                else if (expired)    state_nxt = IDLE;
                else                 state_nxt = GET_MSB;
            end
            PRESENT: begin
                if (!FIR_ready)          state_nxt = PRESENT;
                else if (RxD_data_ready) state_nxt = GET_MSB;
                else                     state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Next values for outputs and datapath registers.
    always_comb begin
        lsb_nxt     = lsb_reg;
        timer_nxt   = timer;
        sample_nxt  = FIR_sample;
        valid_nxt   = FIR_valid_in;
        overrun_nxt = 1'b0;
        timeout_nxt = 1'b0;
        case (state)
            IDLE: begin
                valid_nxt = 1'b0;
                if (RxD_data_ready) begin
                    lsb_nxt   = RxD_data;
                    timer_nxt = '0;
                end
            end
            GET_MSB: begin
                valid_nxt = 1'b0;
                if (RxD_data_ready) begin
                    sample_nxt = {RxD_data, lsb_reg};
                    valid_nxt  = 1'b1;
                end else if (expired) begin
                    timeout_nxt = 1'b1;
                    lsb_nxt     = 8'd0;
                    timer_nxt   = '0;
                end else begin
                    timer_nxt = timer + TMR_W'(1);
                end
            end
            PRESENT: begin
                if (FIR_ready) begin
                    valid_nxt = 1'b0;
                    if (RxD_data_ready) begin
                        lsb_nxt   = RxD_data;
                        timer_nxt = '0;
                    end
                end else if (RxD_data_ready) begin
                    overrun_nxt = 1'b1;
                end
            end
            default: begin
                lsb_nxt    = 8'd0;
                timer_nxt  = '0;
                sample_nxt = 16'd0;
                valid_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_rcv_sample_assembler.sv
// Bench for rcv_sample_assembler: directed scenarios followed by random traffic,
// checked every cycle against a transaction-level reference model.
module tb_rcv_sample_assembler;

    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        strobe = 1'b0;
    logic [7:0]  data = 8'd0;
    logic        ready = 1'b0;
    logic [15:0] FIR_sample;
    logic        FIR_valid_in;
    logic        overrun;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    // Reference model: a held LSB stamped with its arrival cycle, and an optional pending sample.
    int          cyc = 0;
    bit          m_have_lsb;
    logic [7:0]  m_lsb;
    int          m_lsb_time;
    bit          m_pending;
    logic [15:0] m_sample;
    bit          m_ov;
    bit          m_to;

    int valid_cnt;
    int ov_cnt;
    int to_cnt;

    rcv_sample_assembler #(.TIMEOUT_CYCLES(20'(TO)), .TMR_W(20)) dut (
        .clk            (clk),
        .rst            (rst),
        .RxD_data_ready (strobe),
        .RxD_data       (data),
        .FIR_ready      (ready),
        .FIR_sample     (FIR_sample),
        .FIR_valid_in   (FIR_valid_in),
        .overrun        (overrun),
        .timeout_err    (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_update(input bit s, input logic [7:0] d, input bit r, input bit rs);
        m_ov = 1'b0;
        m_to = 1'b0;
        if (rs) begin
            m_have_lsb = 1'b0;
            m_pending  = 1'b0;
            m_sample   = 16'h0000;
        end else if (m_pending) begin
            if (r) begin
                m_pending = 1'b0;
                if (s) begin
                    m_have_lsb = 1'b1;
                    m_lsb      = d;
                    m_lsb_time = cyc;
                end
            end else if (s) begin
                m_ov = 1'b1;
            end
        end else if (m_have_lsb) begin
            if (s) begin
                m_sample   = {d, m_lsb};
                m_pending  = 1'b1;
                m_have_lsb = 1'b0;
            end else if (cyc - m_lsb_time == TO) begin
                m_to       = 1'b1;
                m_have_lsb = 1'b0;
            end
        end else if (s) begin
            m_have_lsb = 1'b1;
            m_lsb      = d;
            m_lsb_time = cyc;
        end
    endtask

    // One clock: drive inputs, advance the model, compare all outputs just after the edge.
    task automatic step(input bit s, input logic [7:0] d, input bit r, input bit rs = 1'b0);
        @(negedge clk);
        strobe = s;
        data   = d;
        ready  = r;
        rst    = rs;
        @(posedge clk);
        cyc++;
        model_update(s, d, r, rs);
        #1;
        chk("valid", 16'(FIR_valid_in), 16'(m_pending));
        chk("sample", FIR_sample, m_sample);
        chk("overrun", 16'(overrun), 16'(m_ov));
        chk("timeout_err", 16'(timeout_err), 16'(m_to));
        if (FIR_valid_in) valid_cnt++;
        if (overrun) ov_cnt++;
        if (timeout_err) to_cnt++;
    endtask

    initial begin
        m_have_lsb = 1'b0;
        m_pending  = 1'b0;
        m_sample   = 16'h0000;
        m_lsb      = 8'h00;
        m_lsb_time = 0;
        valid_cnt  = 0;
        ov_cnt     = 0;
        to_cnt     = 0;

        step(0, 8'h00, 0, 1);
        step(0, 8'h00, 0, 1);
        chk("reset_outputs", {FIR_sample[15:3], FIR_valid_in, overrun, timeout_err}, 16'h0000);

        // Basic pair with FIR always ready
        valid_cnt = 0;
        step(1, 8'h34, 1);
        step(1, 8'h12, 1);
        chk("t1_sample", FIR_sample, 16'h1234);
        chk("t1_valid_rise", 16'(FIR_valid_in), 16'h0001);
        step(0, 8'h00, 1);
        step(0, 8'h00, 1);
        chk("t1_valid_cycles", 16'(valid_cnt), 16'd1);

        // Back-pressure for 10 cycles, with an overrun byte mid-hold
        valid_cnt = 0;
        ov_cnt    = 0;
        step(1, 8'hCD, 0);
        step(1, 8'hAB, 0);
        for (int i = 0; i < 10; i++) begin
            step(i == 4, 8'h55, 0);
            chk("t2_sample_held", FIR_sample, 16'hABCD);
        end
        step(0, 8'h00, 1);
        chk("t2_valid_cycles", 16'(valid_cnt), 16'd11);
        chk("t3_overrun_count", 16'(ov_cnt), 16'd1);
        step(1, 8'h02, 1);
        step(1, 8'h01, 1);
        chk("t3_next_pair", FIR_sample, 16'h0102);
        step(0, 8'h00, 1);

        // Inter-byte timeout
        to_cnt = 0;
        step(1, 8'h11, 1);
        for (int i = 1; i <= 10; i++) begin
            step(0, 8'h00, 1);
            chk("t4_timeout_pulse", 16'(timeout_err), 16'(i == TO));
        end
        chk("t4_timeout_count", 16'(to_cnt), 16'd1);
        step(1, 8'h22, 1);
        step(1, 8'h33, 1);
        chk("t4_resync_sample", FIR_sample, 16'h3322);
        step(0, 8'h00, 1);

        // Strobe on the expiry cycle completes the sample
        step(1, 8'h44, 1);
        for (int i = 1; i < TO; i++) step(0, 8'h00, 1);
        step(1, 8'h99, 1);
        chk("expiry_strobe_wins", FIR_sample, 16'h9944);
        chk("expiry_no_timeout", 16'(timeout_err), 16'h0000);
        step(0, 8'h00, 1);

        // Transfer and new LSB in the same cycle
        ov_cnt = 0;
        step(1, 8'hEE, 0);
        step(1, 8'hFF, 0);
        step(1, 8'h77, 1);
        step(1, 8'h66, 1);
        chk("t5_sample", FIR_sample, 16'h6677);
        chk("t5_no_overrun", 16'(ov_cnt), 16'd0);
        step(0, 8'h00, 1);

        // Reset in GET_MSB and in PRESENT
        step(1, 8'hAA, 1);
        step(0, 8'h00, 1, 1);
        chk("t6_rst_getmsb", {FIR_sample[15:3], FIR_valid_in, overrun, timeout_err}, 16'h0000);
        step(1, 8'hBB, 1);
        step(1, 8'hCC, 1);
        chk("t6_after_rst", FIR_sample, 16'hCCBB);
        step(1, 8'h01, 0);
        step(1, 8'h02, 0);
        step(0, 8'h00, 0, 1);
        chk("t6_rst_present", {FIR_sample[15:3], FIR_valid_in, overrun, timeout_err}, 16'h0000);
        step(1, 8'h05, 1);
        step(1, 8'h06, 1);
        chk("t6_after_rst2", FIR_sample, 16'h0605);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(2) == 0, 8'($urandom), $urandom_range(1) == 1,
                 $urandom_range(199) == 0);
            chk("no_ov_and_to", 16'(overrun & timeout_err), 16'h0000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
